// File: rtl/seq_restoring_div_16by8.sv
// Multi-cycle restoring divider, 16-bit dividend by 8-bit divisor.
// APPROX_LSB low quotient bits are skipped to shorten the iteration.
`timescale 1ns/1ps
module seq_restoring_div_16by8 #(
  parameter int APPROX_LSB = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        dp_active,
  output logic [1:0]  dbg_state
);

  if (APPROX_LSB < 0 || APPROX_LSB > 8) begin : g_bad_param
    $error("seq_restoring_div_16by8: APPROX_LSB must be in 0..8");
  end

  localparam int         N     = 16 - APPROX_LSB;
  localparam logic [4:0] N_CNT = 5'(N);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and DONE holds its outputs until taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  dvsr;
  logic [15:0] sreg;
  logic [7:0]  pr;
  logic [4:0]  cnt;

  logic [8:0]  pr_sh;
  logic [7:0]  pr_diff;
  logic [7:0]  pr_nx;
  logic        qbit;
  logic [15:0] sreg_nx;

  // The partial remainder stays below the divisor, so 8 bits hold it and the
  // 8-bit difference is exact whenever the subtraction is taken.
  always_comb begin
    pr_sh   = {pr, sreg[N-1]};
    qbit    = (pr_sh >= {1'b0, dvsr});
    pr_diff = pr_sh[7:0] - dvsr;
    pr_nx   = qbit ? pr_diff : pr_sh[7:0];
    sreg_nx = {sreg[14:0], qbit};
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) state_nx = (divisor == 8'd0) ? S_DONE : S_CALC;
      S_CALC: if (cnt == 5'd1) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dvsr        <= 8'd0;
      sreg        <= 16'd0;
      pr          <= 8'd0;
      cnt         <= 5'd0;
      quotient    <= 16'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (divisor == 8'd0) begin
              quotient    <= 16'hFFFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
            end else begin
              dvsr <= divisor;
              sreg <= dividend >> APPROX_LSB;
              pr   <= 8'd0;
              cnt  <= N_CNT;
            end
          end
        end
        S_CALC: begin
          pr   <= pr_nx;
          sreg <= sreg_nx;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            // Low N bits of the shift register now hold the quotient.
            quotient    <= sreg_nx << APPROX_LSB;
            remainder   <= pr_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dp_active = (state == S_CALC);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_restoring_div_16by8.sv
// Bench for seq_restoring_div_16by8: exact (APPROX_LSB=0) and approximate
// (APPROX_LSB=4) instances share the input side and are checked independently.
`timescale 1ns/1ps
module tb_seq_restoring_div_16by8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_ready;

  logic        ir0, ov0, z0, dp0;
  logic [15:0] q0;
  logic [7:0]  r0;
  logic [1:0]  st0;
  logic        ir4, ov4, z4, dp4;
  logic [15:0] q4;
  logic [7:0]  r4;
  logic [1:0]  st4;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [24:0] exp_q0[$];
  logic [24:0] exp_q4[$];
  logic [24:0] e0, e4;
  logic        rnd_bp = 1'b0;

  always #5 clk = ~clk;

  seq_restoring_div_16by8 #(.APPROX_LSB(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .dividend(dividend), .divisor(divisor), .out_valid(ov0), .out_ready(out_ready),
    .quotient(q0), .remainder(r0), .div_by_zero(z0), .dp_active(dp0), .dbg_state(st0)
  );

  seq_restoring_div_16by8 #(.APPROX_LSB(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .dividend(dividend), .divisor(divisor), .out_valid(ov4), .out_ready(out_ready),
    .quotient(q4), .remainder(r4), .div_by_zero(z4), .dp_active(dp4), .dbg_state(st4)
  );

  // Reference: plain integer arithmetic on the shifted dividend.
  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] d, input int lsb);
    int s, q, r;
    if (d == 8'd0) return {16'hFFFF, a[7:0], 1'b1};
    s = int'(a) >> lsb;
    q = (s / int'(d)) << lsb;
    r = s % int'(d);
    return {q[15:0], r[7:0], 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov0 && out_ready) begin
      if (exp_q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL mon0: unexpected result 0x%0h", {q0, r0, z0});
      end else begin
        e0 = exp_q0.pop_front();
        chk("mon0 {q,r,dbz}", 32'({q0, r0, z0}), 32'(e0));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov4 && out_ready) begin
      if (exp_q4.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL mon4: unexpected result 0x%0h", {q4, r4, z4});
      end else begin
        e4 = exp_q4.pop_front();
        chk("mon4 {q,r,dbz}", 32'({q4, r4, z4}), 32'(e4));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [15:0] a, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!(ir0 && ir4)) begin
      t++;
      if (t > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL issue_timeout: in_ready0=%0b in_ready4=%0b, expected both 1", ir0, ir4);
        return;
      end
      @(negedge clk);
    end
    dividend = a;
    divisor  = d;
    in_valid = 1'b1;
    exp_q0.push_back(model(a, d, 0));
    exp_q4.push_back(model(a, d, 4));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // c counts rising edges since the acceptance edge.
  task automatic measure(input string tag, input int exp_lat0, input int exp_lat4, input bit is_dz);
    int lat0, lat4, ndp0, ndp4;
    lat0 = -1; lat4 = -1; ndp0 = 0; ndp4 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dp0) ndp0++;
      if (dp4) ndp4++;
      if (lat0 < 0 && ov0) lat0 = c;
      if (lat4 < 0 && ov4) lat4 = c;
      if (lat0 >= 0 && lat4 >= 0) break;
      @(posedge clk);
    end
    chk({tag, " lat0"}, 32'(lat0), 32'(exp_lat0));
    chk({tag, " lat4"}, 32'(lat4), 32'(exp_lat4));
    chk({tag, " dp_cycles0"}, 32'(ndp0), is_dz ? 32'd0 : 32'(exp_lat0));
    chk({tag, " dp_cycles4"}, 32'(ndp4), is_dz ? 32'd0 : 32'(exp_lat4));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ov0"}, 32'(ov0), 32'd0);
    chk({tag, " ir0"}, 32'(ir0), 32'd1);
    chk({tag, " dp0"}, 32'(dp0), 32'd0);
    chk({tag, " q0r0z0"}, 32'({q0, r0, z0}), 32'd0);
    chk({tag, " ov4"}, 32'(ov4), 32'd0);
    chk({tag, " ir4"}, 32'(ir4), 32'd1);
    chk({tag, " dp4"}, 32'(dp4), 32'd0);
    chk({tag, " q4r4z4"}, 32'({q4, r4, z4}), 32'd0);
  endtask

  logic [15:0] dir_a [6] = '{16'd1000, 16'd65535, 16'd65535, 16'd5, 16'h1234, 16'd0};
  logic [7:0]  dir_d [6] = '{8'd7, 8'd255, 8'd1, 8'd10, 8'd0, 8'd3};

  initial begin
    int t;
    logic [24:0] s0, s4;
    logic [15:0] ra;
    logic [7:0]  rd;
    rst_n = 1'b0; in_valid = 1'b0; dividend = 16'd0; divisor = 8'd0; out_ready = 1'b1;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(dir_a[i], dir_d[i]);
      if (dir_d[i] == 8'd0) measure($sformatf("dir%0d", i), 0, 0, 1'b1);
      else                  measure($sformatf("dir%0d", i), 16, 12, 1'b0);
    end

    // Backpressure in DONE with a stray request that must be ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(16'd1000, 8'd7);
    t = 0;
    @(negedge clk);
    while (!(ov0 && ov4) && t < 40) begin t++; @(negedge clk); end
    chk("stall reached_done", 32'(ov0 && ov4), 32'd1);
    s0 = model(16'd1000, 8'd7, 0);
    s4 = model(16'd1000, 8'd7, 4);
    for (int k = 0; k < 5; k++) begin
      chk("stall ov0", 32'(ov0), 32'd1);
      chk("stall ir0", 32'(ir0), 32'd0);
      chk("stall ir4", 32'(ir4), 32'd0);
      chk("stall hold0", 32'({q0, r0, z0}), 32'(s0));
      chk("stall hold4", 32'({q4, r4, z4}), 32'(s4));
      dividend = 16'd77; divisor = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release ir0", 32'(ir0), 32'd1);
    chk("release ir4", 32'(ir4), 32'd1);
    chk("release ov0", 32'(ov0), 32'd0);

    // Reset in the middle of an operation discards it.
    issue(16'd1000, 8'd7);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    exp_q0.delete();
    exp_q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd200, 8'd9);
    measure("post_reset", 16, 12, 1'b0);

    // Random operands under random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0:       rd = 8'd0;
        1:       rd = 8'($urandom_range(1, 3));
        default: rd = 8'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(0, 300));
      issue(ra, rd);
    end
    @(negedge clk);
    rnd_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q4.size() != 0) && t < 200) begin t++; @(negedge clk); end
    chk("drain q0", 32'(exp_q0.size()), 32'd0);
    chk("drain q4", 32'(exp_q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
